// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment display driver.
// Glyph codes are active-high, bit order {dp,g,f,e,d,c,b,a}.
package seg_pkg;

  typedef logic [3:0] nibble_t;

  localparam int unsigned DIG_NUM = 6;

  localparam nibble_t SIGN_POS = 4'hA;
  localparam nibble_t SIGN_NEG = 4'hB;

  localparam logic [7:0] GLYPH_0     = 8'h3F;
  localparam logic [7:0] GLYPH_1     = 8'h06;
  localparam logic [7:0] GLYPH_2     = 8'h5B;
  localparam logic [7:0] GLYPH_3     = 8'h4F;
  localparam logic [7:0] GLYPH_4     = 8'h66;
  localparam logic [7:0] GLYPH_5     = 8'h6D;
  localparam logic [7:0] GLYPH_6     = 8'h7D;
  localparam logic [7:0] GLYPH_7     = 8'h07;
  localparam logic [7:0] GLYPH_8     = 8'h7F;
  localparam logic [7:0] GLYPH_9     = 8'h6F;
  localparam logic [7:0] GLYPH_MINUS = 8'h40;
  localparam logic [7:0] GLYPH_BLANK = 8'h00;
  localparam logic [7:0] DP_MASK     = 8'h80;

  // BCD digit to glyph; codes A-F render blank.
  function automatic logic [7:0] digit_glyph(input nibble_t n);
    logic [7:0] g;
    case (n)
      4'd0:    g = GLYPH_0;
      4'd1:    g = GLYPH_1;
      4'd2:    g = GLYPH_2;
      4'd3:    g = GLYPH_3;
      4'd4:    g = GLYPH_4;
      4'd5:    g = GLYPH_5;
      4'd6:    g = GLYPH_6;
      4'd7:    g = GLYPH_7;
      4'd8:    g = GLYPH_8;
      4'd9:    g = GLYPH_9;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg_glyph_dec.sv
// Combinational glyph decoder for one display position.
// Ports:
//   nibble  - BCD value (or sign code on the leftmost digit)
//   dig_idx - digit position, 0 = rightmost
//   dp_en   - light the decimal point on this digit
//   glyph   - active-high segment pattern {dp,g,f,e,d,c,b,a}
module seg_glyph_dec
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic [2:0] dig_idx,
  input  logic       dp_en,
  output logic [7:0] glyph
);

  always_comb begin
    glyph = GLYPH_BLANK;
    if (dig_idx == 3'(DIG_NUM - 1)) begin
      // Sign position: only a negative sign draws anything.
      if (nibble == SIGN_NEG) begin
        glyph = GLYPH_MINUS;
      end
    end else if (dig_idx == 3'(DIG_NUM - 2) && nibble == 4'h0) begin
      // Tens position: suppress the leading zero.
      glyph = GLYPH_BLANK;
    end else begin
      glyph = digit_glyph(nibble);
    end
    if (dp_en) begin
      glyph = glyph | DP_MASK;
    end
  end

endmodule

// File: rtl/seg_dyn_scan.sv
// Six-digit multiplexed seven-segment driver.
// Scans digits rightmost first, one slot each, with a dead interval at the start
// of every slot, a per-frame snapshot of the display word, and a blink while the
// alarm is raised.
// Ports:
//   clk      - system clock
//   rst      - synchronous active-high reset
//   dis_data - {sign, tens, ones, 0.1, 0.01, 0.001}, one nibble each
//   alarm    - enables blinking of the whole display
//   sel      - registered digit enables, sel[0] = rightmost digit
//   seg      - registered segment lines {dp,g,f,e,d,c,b,a}
module seg_dyn_scan
  import seg_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned SCAN_HZ     = 1000,
  parameter int unsigned DEAD        = 16,
  parameter int unsigned BLINK_HZ    = 2,
  parameter bit          SEG_ACT_LOW = 1'b1,
  parameter bit          SEL_ACT_LOW = 1'b1,
  parameter int unsigned DP_DIG      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] dis_data,
  input  logic        alarm,
  output logic [5:0]  sel,
  output logic [7:0]  seg
);

  localparam int unsigned SLOT   = CLK_FREQ / SCAN_HZ;
  localparam int unsigned HALF   = CLK_FREQ / (2 * BLINK_HZ);
  localparam int unsigned SLOT_W = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam int unsigned HALF_W = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [5:0] SEL_OFF = SEL_ACT_LOW ? 6'h3F : 6'h00;
  localparam logic [7:0] SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;

  logic [SLOT_W-1:0] slot_cnt_q;
  logic [2:0]        dig_idx_q;
  logic [HALF_W-1:0] blink_cnt_q;
  logic              blink_on_q;
  logic [23:0]       frame_q;
  logic              fresh_q;  // first cycle after reset: frame_q not yet loaded

  logic              slot_wrap;
  logic              frame_wrap;
  logic [23:0]       frame_src;
  logic [3:0]        nibble;
  logic              blink_off;
  logic              dp_en;
  logic              in_dead;
  logic [7:0]        glyph;
  logic [5:0]        sel_ah;
  logic [5:0]        sel_d;
  logic [7:0]        seg_d;

  assign slot_wrap  = (slot_cnt_q == SLOT_W'(SLOT - 1));
  assign frame_wrap = slot_wrap && (dig_idx_q == 3'(DIG_NUM - 1));

  // Bypass the frame register until its first load so digit 0 of the first
  // frame already comes from the live word.
  assign frame_src = fresh_q ? dis_data : frame_q;
  assign nibble    = frame_src[{dig_idx_q, 2'b00} +: 4];

  // alarm is qualified here so dropping it restores scanning on the same edge.
  assign blink_off = alarm && !blink_on_q;
  assign dp_en     = (dig_idx_q == 3'(DP_DIG)) && !blink_off;
  assign in_dead   = (slot_cnt_q < SLOT_W'(DEAD));

  seg_glyph_dec u_glyph_dec (
    .nibble  (nibble),
    .dig_idx (dig_idx_q),
    .dp_en   (dp_en),
    .glyph   (glyph)
  );

  always_comb begin
    sel_ah = 6'h00;
    if (!in_dead && !blink_off) begin
      sel_ah = 6'b1 << dig_idx_q;
    end
    sel_d = SEL_ACT_LOW ? ~sel_ah : sel_ah;
    seg_d = SEG_ACT_LOW ? ~glyph : glyph;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_q <= '0;
      dig_idx_q  <= 3'd0;
      frame_q    <= 24'h0;
      fresh_q    <= 1'b1;
      sel        <= SEL_OFF;
      seg        <= SEG_OFF;
    end else begin
      sel     <= sel_d;
      seg     <= seg_d;
      fresh_q <= 1'b0;
      if (fresh_q || frame_wrap) begin
        frame_q <= dis_data;
      end
      if (slot_wrap) begin
        slot_cnt_q <= '0;
        dig_idx_q  <= (dig_idx_q == 3'(DIG_NUM - 1)) ? 3'd0 : dig_idx_q + 3'd1;
      end else begin
        slot_cnt_q <= slot_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !alarm) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else if (blink_cnt_q == HALF_W'(HALF - 1)) begin
      blink_cnt_q <= '0;
      blink_on_q  <= !blink_on_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_dyn_scan.sv
module tb_seg_dyn_scan;

  localparam int SLOT   = 10;
  localparam int DEAD   = 2;
  localparam int HALF   = 100;
  localparam int DP_DIG = 3;
  localparam int FRAME  = 6 * SLOT;

  logic        clk = 1'b0;
  logic        rst;
  logic        alarm;
  logic [23:0] dis_data;
  logic [5:0]  sel;
  logic [7:0]  seg;

  int errors = 0;
  int checks = 0;

  // Reference model state: t counts edges since reset release.
  int          t;
  int          alarm_run;
  logic [23:0] snap;
  logic [5:0]  exp_sel;
  logic [7:0]  exp_seg;

  logic [7:0] num_glyph [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  always #5 clk = ~clk;

  seg_dyn_scan #(
    .CLK_FREQ    (1000),
    .SCAN_HZ     (100),
    .DEAD        (DEAD),
    .BLINK_HZ    (5),
    .SEG_ACT_LOW (1'b1),
    .SEL_ACT_LOW (1'b1),
    .DP_DIG      (DP_DIG)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .dis_data (dis_data),
    .alarm    (alarm),
    .sel      (sel),
    .seg      (seg)
  );

  function automatic logic [7:0] ref_glyph(input logic [23:0] word, input int d, input bit dp);
    logic [3:0] n;
    logic [7:0] g;
    n = word[d*4 +: 4];
    if (d == 5)                 g = (n == 4'hB) ? 8'h40 : 8'h00;
    else if (n > 4'd9)          g = 8'h00;
    else if (d == 4 && n == 0)  g = 8'h00;
    else                        g = num_glyph[n];
    if (dp) g = g | 8'h80;
    return g;
  endfunction

  // One clock edge; updates the model's expected outputs for this edge, then
  // returns 1 time unit later so the DUT outputs are stable.
  task automatic tick();
    logic [23:0] cur_dis;
    logic        cur_alarm;
    int          slot, idx;
    bit          off;
    @(posedge clk);
    cur_dis   = dis_data;
    cur_alarm = alarm;
    if (rst) begin
      t         = 0;
      alarm_run = 0;
      exp_sel   = 6'h3F;
      exp_seg   = 8'hFF;
    end else begin
      t++;
      if (t == 1) snap = cur_dis;
      alarm_run = cur_alarm ? alarm_run + 1 : 0;
      off  = cur_alarm && ((((alarm_run - 1) / HALF) % 2) == 1);
      slot = (t - 1) % SLOT;
      idx  = ((t - 1) / SLOT) % 6;
      exp_sel = (slot < DEAD || off) ? 6'h3F : ~(6'b1 << idx);
      exp_seg = ~ref_glyph(snap, idx, (idx == DP_DIG) && !off);
      if (t % FRAME == 0) snap = cur_dis;
    end
    #1;
  endtask

  task automatic do_reset(input logic [23:0] word);
    dis_data = word;
    alarm    = 1'b0;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if (sel !== 6'h3F || seg !== 8'hFF) begin
      errors++;
      $display("FAIL reset_initial sel=%h seg=%h expected sel=3f seg=ff", sel, seg);
    end
    do_reset(24'hA25062);
    repeat (25) tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (sel !== 6'h3F || seg !== 8'hFF) begin
        errors++;
        $display("FAIL reset_hold cycle=%0d sel=%h seg=%h expected sel=3f seg=ff", k, sel, seg);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (sel !== ((k >= 3) ? 6'h3E : 6'h3F)) begin
        errors++;
        $display("FAIL reset_release cycle=%0d sel=%h expected %h", k, sel,
                 (k >= 3) ? 6'h3E : 6'h3F);
      end
    end
  endtask

  task automatic test_scan();
    logic [7:0] tbl [6] = '{8'hA4, 8'h82, 8'hC0, 8'h12, 8'hA4, 8'hFF};
    int lows [6] = '{0, 0, 0, 0, 0, 0};
    do_reset(24'hA25062);
    for (int c = 0; c < FRAME; c++) begin
      tick();
      checks++;
      if (sel !== exp_sel || seg !== exp_seg) begin
        errors++;
        $display("FAIL scan_model t=%0d sel=%h seg=%h expected sel=%h seg=%h",
                 t, sel, seg, exp_sel, exp_seg);
      end
      for (int i = 0; i < 6; i++) begin
        if (sel[i] === 1'b0) begin
          lows[i]++;
          checks++;
          if (seg !== tbl[i]) begin
            errors++;
            $display("FAIL scan_glyph digit=%0d seg=%h expected %h", i, seg, tbl[i]);
          end
        end
      end
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (lows[i] != SLOT - DEAD) begin
        errors++;
        $display("FAIL scan_width digit=%0d low_cycles=%0d expected %0d", i, lows[i], SLOT - DEAD);
      end
    end
  endtask

  task automatic test_negative();
    logic [7:0] tbl [6] = '{8'h92, 8'hA4, 8'hF9, 8'h30, 8'hFF, 8'hBF};
    do_reset(24'hB03125);
    for (int c = 0; c < FRAME; c++) begin
      tick();
      checks++;
      if (sel !== exp_sel || seg !== exp_seg) begin
        errors++;
        $display("FAIL negative_model t=%0d sel=%h seg=%h expected sel=%h seg=%h",
                 t, sel, seg, exp_sel, exp_seg);
      end
      for (int i = 0; i < 6; i++) begin
        if (sel[i] === 1'b0) begin
          checks++;
          if (seg !== tbl[i]) begin
            errors++;
            $display("FAIL negative_glyph digit=%0d seg=%h expected %h", i, seg, tbl[i]);
          end
        end
      end
    end
  endtask

  task automatic test_invalid();
    logic [7:0] tbl [6] = '{8'hC0, 8'hC0, 8'hFF, 8'h40, 8'hFF, 8'hFF};
    do_reset(24'hAF0C00);
    for (int c = 0; c < FRAME; c++) begin
      tick();
      checks++;
      if (sel !== exp_sel || seg !== exp_seg) begin
        errors++;
        $display("FAIL invalid_model t=%0d sel=%h seg=%h expected sel=%h seg=%h",
                 t, sel, seg, exp_sel, exp_seg);
      end
      for (int i = 0; i < 6; i++) begin
        if (sel[i] === 1'b0) begin
          checks++;
          if (seg !== tbl[i]) begin
            errors++;
            $display("FAIL invalid_glyph digit=%0d seg=%h expected %h", i, seg, tbl[i]);
          end
        end
      end
    end
  endtask

  task automatic test_frame_coherence();
    do_reset(24'hA25062);
    while (t < 25) tick();
    dis_data = 24'hA30000;  // changed while digit 2 is on
    while (t < 2 * FRAME + 10) begin
      tick();
      checks++;
      if (sel !== exp_sel || seg !== exp_seg) begin
        errors++;
        $display("FAIL frame_model t=%0d sel=%h seg=%h expected sel=%h seg=%h",
                 t, sel, seg, exp_sel, exp_seg);
      end
      if (t == 36 || t == 46 || t == 66) begin
        checks++;
        if ((t == 36 && (sel !== 6'h37 || seg !== 8'h12)) ||
            (t == 46 && (sel !== 6'h2F || seg !== 8'hA4)) ||
            (t == 66 && (sel !== 6'h3E || seg !== 8'hC0))) begin
          errors++;
          $display("FAIL frame_snapshot t=%0d sel=%h seg=%h", t, sel, seg);
        end
      end
    end
  endtask

  task automatic test_blink();
    do_reset(24'hA25062);
    repeat (3) tick();
    alarm = 1'b1;
    for (int j = 0; j < 550; j++) begin
      tick();
      checks++;
      if (sel !== exp_sel || seg !== exp_seg) begin
        errors++;
        $display("FAIL blink_model j=%0d sel=%h seg=%h expected sel=%h seg=%h",
                 j, sel, seg, exp_sel, exp_seg);
      end
      if (((j / HALF) % 2) == 1) begin
        checks++;
        if (sel !== 6'h3F) begin
          errors++;
          $display("FAIL blink_off j=%0d sel=%h expected 3f", j, sel);
        end
      end
    end
    alarm = 1'b0;  // dropped during an OFF half-period
    tick();
    checks++;
    if (sel !== exp_sel || seg !== exp_seg || (exp_sel != 6'h3F && sel === 6'h3F)) begin
      errors++;
      $display("FAIL blink_release sel=%h seg=%h expected sel=%h seg=%h",
               sel, seg, exp_sel, exp_seg);
    end
  endtask

  task automatic test_random();
    logic [23:0] w;
    do_reset(24'hA12345);
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 16) == 0) begin
        for (int n = 0; n < 5; n++) w[n*4 +: 4] = 4'($urandom_range(0, 11));
        w[23:20] = ($urandom_range(0, 3) == 0) ? 4'($urandom()) :
                   (($urandom_range(0, 1) == 1) ? 4'hB : 4'hA);
        dis_data = w;
      end
      if ($urandom_range(0, 149) == 0) alarm = ~alarm;
      rst = ($urandom_range(0, 299) == 0);
      tick();
      checks++;
      if (sel !== exp_sel || seg !== exp_seg) begin
        errors++;
        $display("FAIL random t=%0d sel=%h seg=%h expected sel=%h seg=%h",
                 t, sel, seg, exp_sel, exp_seg);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    alarm     = 1'b0;
    dis_data  = 24'hA00000;
    t         = 0;
    alarm_run = 0;
    snap      = 24'h0;
    exp_sel   = 6'h3F;
    exp_seg   = 8'hFF;
    test_reset();
    test_scan();
    test_negative();
    test_invalid();
    test_frame_coherence();
    test_blink();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
